address_unit: RTL

//  Memory address generator for the 6502 core; consumes the control unit's per-state strobes.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/address_unit_byte_reg.sv | 22 ++
 rtl/address_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared 6502 core definitions: address-source encodings used by both
// control_unit (producer of address_select) and address_unit (consumer).
package cpu_pkg;

   typedef enum logic [2:0] {
      ADDR_SEL_PC         = 3'd0,
      ADDR_SEL_ZERO       = 3'd1,
      ADDR_SEL_ABS        = 3'd2,
      ADDR_SEL_IND_ZERO_0 = 3'd3,
      ADDR_SEL_IND_ZERO_1 = 3'd4,
      ADDR_SEL_IND_ABS_0  = 3'd5,
      ADDR_SEL_IND_ABS_1  = 3'd6,
      ADDR_SEL_RESERVED   = 3'd7
   } addr_sel_e;

   localparam logic [7:0] ZERO_PAGE = 8'h00;

   // Zero-page pointer: high byte forced to page 0, so lo+1 never carries out.
   function automatic logic [15:0] zp_addr(input logic [7:0] lo);
      return {ZERO_PAGE, lo};
   endfunction

endpackage

// File: rtl/address_unit_byte_reg.sv
// 8-bit register with synchronous active-high reset and load enable;
// holds one of the address unit's operand bytes.
module byte_reg (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [7:0] i_d,
   output logic [7:0] o_q
);

   logic [7:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_q <= '0;
      else if (i_load)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/address_unit.sv
// Memory address generator: PC plus direct/indirect pointer bytes, with a
// combinational mux onto the 16-bit address bus selected by address_select.
module address_unit
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  alu_result,
   input  logic        increment_pc,
   input  logic        pc_load,
   input  logic        dirl_load,
   input  logic        dirh_load,
   input  logic        indirl_load,
   input  logic        indirh_load,
   input  logic [2:0]  address_select,
   output logic [15:0] address,
   output logic [15:0] pc
);

   logic [15:0] r_pc;
   logic [7:0]  w_dirl;
   logic [7:0]  w_dirh;
   logic [7:0]  w_indirl;
   logic [7:0]  w_indirh;
   logic [15:0] w_dir;
   logic [15:0] w_indir;
   logic [7:0]  w_indirl_inc;
   addr_sel_e   w_sel;
   logic [15:0] w_address;

   byte_reg u_dirl (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_load (dirl_load),
      .i_d    (alu_result),
      .o_q    (w_dirl)
   );

   byte_reg u_dirh (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_load (dirh_load),
      .i_d    (alu_result),
      .o_q    (w_dirh)
   );

   byte_reg u_indirl (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_load (indirl_load),
      .i_d    (alu_result),
      .o_q    (w_indirl)
   );

   byte_reg u_indirh (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_load (indirh_load),
      .i_d    (alu_result),
      .o_q    (w_indirh)
   );

   assign w_dir        = {w_dirh, w_dirl};
   assign w_indir      = {w_indirh, w_indirl};
   assign w_indirl_inc = w_indirl + 8'd1;

   // Jump target is the pre-edge {dirh,dirl}; a load in the same cycle is not seen.
   always_ff @(posedge clk) begin
      if (rst)
         r_pc <= RESET_PC;
      else if (pc_load)
         r_pc <= w_dir;
      else if (increment_pc)
         r_pc <= r_pc + 16'd1;
   end

   assign w_sel = addr_sel_e'(address_select);

   always_comb begin
      w_address = r_pc;
      unique case (w_sel)
         ADDR_SEL_PC:         w_address = r_pc;
         ADDR_SEL_ZERO:       w_address = zp_addr(w_dirl);
         ADDR_SEL_ABS:        w_address = w_dir;
         ADDR_SEL_IND_ZERO_0: w_address = zp_addr(w_indirl);
         ADDR_SEL_IND_ZERO_1: w_address = zp_addr(w_indirl_inc);
         ADDR_SEL_IND_ABS_0:  w_address = w_indir;
         ADDR_SEL_IND_ABS_1:  w_address = w_indir + 16'd1;
         ADDR_SEL_RESERVED:   w_address = r_pc;
         default:             w_address = r_pc;
      endcase
   end

   assign address = w_address;
   assign pc      = r_pc;

endmodule
